// File: rtl/calib_pulse_seq_pkg.sv
// Shared types and constants for the calibration pulse sequencer.
package calib_seq_pkg;

  localparam int CNT_W_DEF = 12;
  localparam int DLY_W_DEF = 8;
  localparam int WID_W_DEF = 4;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PULSE    = 3'd1;
  localparam logic [2:0] ST_WAIT_TRG = 3'd2;
  localparam logic [2:0] ST_TRIG     = 3'd3;
  localparam logic [2:0] ST_GAP      = 3'd4;
  localparam logic [2:0] ST_FINISH   = 3'd5;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    PULSE    = ST_PULSE,
    WAIT_TRG = ST_WAIT_TRG,
    TRIG     = ST_TRIG,
    GAP      = ST_GAP,
    FINISH   = ST_FINISH
  } state_t;

  localparam logic SEL_INJ = 1'b1;
  localparam logic SEL_EXT = 1'b0;

endpackage

// File: rtl/calib_pulse_seq_if.sv
// Control, configuration and pulse outputs of the sequencer.
interface calib_pulse_seq_if
  import calib_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DLY_W = DLY_W_DEF,
  parameter int WID_W = WID_W_DEF
) ();

  logic             START;
  logic             ABORT;
  logic             INJ_SEL;
  logic [CNT_W-1:0] NPULSE;
  logic [WID_W-1:0] PLS_WIDTH;
  logic [DLY_W-1:0] TRG_DLY;
  logic [DLY_W-1:0] PERIOD;

  logic             INJ_PLS;
  logic             EXT_PLS;
  logic             TRG_REQ;
  logic             BUSY;
  logic             DONE;
  logic [CNT_W-1:0] PLS_CNT;

  modport master (
    output START, ABORT, INJ_SEL,
    output NPULSE, PLS_WIDTH,
    output TRG_DLY, PERIOD,
    input  INJ_PLS, EXT_PLS,
    input  TRG_REQ, BUSY, DONE,
    input  PLS_CNT
  );

  modport slave (
    input  START, ABORT, INJ_SEL,
    input  NPULSE, PLS_WIDTH,
    input  TRG_DLY, PERIOD,
    output INJ_PLS, EXT_PLS,
    output TRG_REQ, BUSY, DONE,
    output PLS_CNT
  );

endinterface

// File: rtl/calib_pulse_seq_dly_cnt.sv
// Loadable down-counter timing each sequencer phase.
module calib_dly_cnt #(
  parameter int W = 8
) (
  input  logic         CLK40,
  input  logic         rst_resync,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] value,
  output logic         zero
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt;

  always_ff @(posedge CLK40 or posedge rst_resync) begin
    if (rst_resync) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (en && cnt != '0) begin
      cnt <= cnt - ONE;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/calib_pulse_seq.sv
// Calibration pulse burst sequencer; CALSEQ_TRG_EN adds the
// post-pulse delayed trigger request (WAIT_TRG/TRIG phases).
module calib_pulse_seq
  import calib_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DLY_W = DLY_W_DEF,
  parameter int WID_W = WID_W_DEF
) (
  input  logic             CLK40,
  input  logic             rst_resync,
  calib_pulse_seq_if.slave bus
);

  localparam int CW = (DLY_W > WID_W) ? DLY_W : WID_W;
  localparam logic [CW-1:0]    ONE   = CW'(1);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  state_t state, nxt;

  logic             sel_q;
  logic [CNT_W-1:0] npl_q;
  logic [WID_W-1:0] wid_q;
  logic [DLY_W-1:0] per_q;
  logic [CNT_W-1:0] cnt_q;
  logic             inj_q, ext_q;
  logic             busy_q, done_q;

  logic             sel;
  logic [WID_W-1:0] cfg_w;
  logic [CW-1:0]    w_m1, per_m1, ld_val;
  logic             ld, zero, last;
  state_t           after_pulse;

  // In IDLE the live inputs are the ones about to be latched
  assign sel   = (state == IDLE) ? bus.INJ_SEL   : sel_q;
  assign cfg_w = (state == IDLE) ? bus.PLS_WIDTH : wid_q;

  assign w_m1   = (cfg_w == '0) ? '0 : CW'(cfg_w) - ONE;
  assign per_m1 = (per_q == '0) ? '0 : CW'(per_q) - ONE;
  assign last   = (npl_q != '0) && (cnt_q == npl_q);

`ifdef CALSEQ_TRG_EN
  logic [DLY_W-1:0] dly_q;
  logic [CW-1:0]    dly_m1;
  logic             trg_q;

  assign dly_m1      = CW'(dly_q) - ONE;
  assign after_pulse = (dly_q == '0) ? TRIG : WAIT_TRG;
  assign bus.TRG_REQ = trg_q;
`else
  assign after_pulse = GAP;
  assign bus.TRG_REQ = 1'b0;
`endif

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:     if (bus.START && !bus.ABORT) nxt = PULSE;
      PULSE:    if (zero) nxt = after_pulse;
`ifdef CALSEQ_TRG_EN
      WAIT_TRG: if (zero) nxt = TRIG;
      TRIG:     nxt = GAP;
`endif
      GAP:      if (zero) nxt = last ? FINISH : PULSE;
      FINISH:   nxt = IDLE;
      default:  nxt = IDLE;
    endcase
    if (state != IDLE && bus.ABORT) nxt = IDLE;
  end

  // Counter is reloaded with (phase length - 1) on every phase entry
  always_comb begin
    ld_val = '0;
    unique case (1'b1)
      (nxt == PULSE):    ld_val = w_m1;
`ifdef CALSEQ_TRG_EN
      (nxt == WAIT_TRG): ld_val = dly_m1;
`endif
      (nxt == GAP):      ld_val = per_m1;
      default:           ld_val = '0;
    endcase
  end

  assign ld = (nxt != state);

  calib_dly_cnt #(.W(CW)) u_dly (
    .CLK40      (CLK40),
    .rst_resync (rst_resync),
    .load       (ld),
    .en         (state != IDLE),
    .value      (ld_val),
    .zero       (zero)
  );

  always_ff @(posedge CLK40 or posedge rst_resync) begin
    if (rst_resync) begin
      state  <= IDLE;
      sel_q  <= 1'b0;
      npl_q  <= '0;
      wid_q  <= '0;
      per_q  <= '0;
      cnt_q  <= '0;
      inj_q  <= 1'b0;
      ext_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef CALSEQ_TRG_EN
      dly_q  <= '0;
      trg_q  <= 1'b0;
`endif
    end else begin
      state  <= nxt;
      inj_q  <= (nxt == PULSE) && (sel == SEL_INJ);
      ext_q  <= (nxt == PULSE) && (sel == SEL_EXT);
      busy_q <= (nxt != IDLE) && (nxt != FINISH);
      done_q <= (nxt == FINISH);
`ifdef CALSEQ_TRG_EN
      trg_q  <= (nxt == TRIG);
`endif
      if (state == IDLE && nxt == PULSE) begin
        sel_q <= bus.INJ_SEL;
        npl_q <= bus.NPULSE;
        wid_q <= bus.PLS_WIDTH;
        per_q <= bus.PERIOD;
`ifdef CALSEQ_TRG_EN
        dly_q <= bus.TRG_DLY;
`endif
        cnt_q <= ONE_C;
      end else if (nxt == PULSE && state != PULSE) begin
        cnt_q <= cnt_q + ONE_C;
      end
    end
  end

  assign bus.INJ_PLS = inj_q;
  assign bus.EXT_PLS = ext_q;
  assign bus.BUSY    = busy_q;
  assign bus.DONE    = done_q;
  assign bus.PLS_CNT = cnt_q;

endmodule
